// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory (1-cycle read
// latency) between the instruction-fetch port (IF) and the load/store
// port (LS). LS wins by default; a starvation counter hands IF the next
// contested cycle after MAX_WAIT consecutive losses.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   if_req/if_addr  fetch request and word address, held until if_gnt
//   if_gnt          fetch accepted this cycle (combinational)
//   if_rvalid/rdata fetch read data, one cycle after if_gnt
//   ls_req/we/be/addr/wdata  load/store request, held until ls_gnt
//   ls_gnt          load/store accepted this cycle (combinational)
//   ls_rvalid/rdata load read data, one cycle after a read ls_gnt
//   mem_*           single-port memory interface
module mem_arbiter #(
  parameter int unsigned s        = 32,
  parameter int unsigned AW       = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [s-1:0]    if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [s/8-1:0]  ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [s-1:0]    ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [s-1:0]    ls_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [s/8-1:0]  mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [s-1:0]    mem_wdata,
  input  logic [s-1:0]    mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic {
    LS_PRIO = 1'b0,
    IF_PRIO = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  // Same-cycle grant; reset masks both grants so no access leaks out.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (if_req && (!ls_req || state == IF_PRIO)) begin
        if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end
    end
  end

  // Memory drive follows the granted port; idle buses are held at zero.
  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_we    = ls_we;
      mem_be    = ls_we ? ls_be : '0;
      mem_wdata = ls_wdata;
    end
  end

  // Both read ports see the raw memory data; rvalid tells them who owns it.
  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;

  // Read-return owner tracking plus the starvation FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LS_PRIO;
      wait_cnt  <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_gnt & ~ls_we;

      if (if_gnt || !if_req) begin
        wait_cnt <= '0;
      end else if (ls_gnt && wait_cnt != CW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      case (state)
        LS_PRIO: begin
          // Flip on the loss that brings the counter up to MAX_WAIT.
          if (if_req && ls_gnt && wait_cnt == CW'(MAX_WAIT - 1)) begin
            state <= IF_PRIO;
          end
        end
        IF_PRIO: begin
          if (if_gnt) begin
            state <= LS_PRIO;
          end
        end
        default: state <= LS_PRIO;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// single-port memory and a read-return scoreboard.
module tb_mem_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned MAXW  = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [BW-1:0] ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.s(DW), .AW(AW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural memory with a back-door preload/clear port.
  logic [DW-1:0] mem [DEPTH];
  logic          pl_en;
  logic          pl_clr;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++) begin
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    bit            is_if;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            vectors    = 0;
  int            miscompares = 0;

  // One clock; afterwards check read returns against the scoreboard.
  task automatic tick();
    sb_t           e;
    bit            exp_if;
    bit            exp_ls;
    logic [DW-1:0] exp_d;
    @(posedge clk);
    #1;
    exp_if = 1'b0;
    exp_ls = 1'b0;
    exp_d  = '0;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      exp_if = e.is_if;
      exp_ls = !e.is_if;
      exp_d  = e.data;
    end
    vectors++;
    if (if_rvalid !== exp_if || ls_rvalid !== exp_ls) begin
      miscompares++;
      $display("FAIL rvalid @%0t: if_rvalid=%b ls_rvalid=%b expected %b/%b",
               $time, if_rvalid, ls_rvalid, exp_if, exp_ls);
    end
    if (exp_if) begin
      vectors++;
      if (if_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL if_rdata @%0t: got %h expected %h", $time, if_rdata, exp_d);
      end
    end
    if (exp_ls) begin
      vectors++;
      if (ls_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL ls_rdata @%0t: got %h expected %h", $time, ls_rdata, exp_d);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input bit is_if, input logic [DW-1:0] data);
    sb_t e;
    e.is_if = is_if;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic set_idle();
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_be    = '0;
    ls_addr  = '0;
    ls_wdata = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    if_req = 1'b1;
    ls_req = 1'b1;
    pl_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_gnt: if_gnt=%b ls_gnt=%b mem_en=%b expected 0/0/0",
                 if_gnt, ls_gnt, mem_en);
      end
      tick();
      pl_clr = 1'b0;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (if_gnt !== 1'b0 || ls_gnt !== 1'b1 || mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_gnt: if_gnt=%b ls_gnt=%b mem_en=%b expected 0/1/1",
               if_gnt, ls_gnt, mem_en);
    end
    push_exp(1'b0, ref_mem[ls_addr]);
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_if_read();
    preload(AW'(5), 32'hDEADBEEF);
    if_req  = 1'b1;
    if_addr = AW'(5);
    #1;
    vectors++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_en !== 1'b1 ||
        mem_addr !== AW'(5) || mem_we !== 1'b0 || mem_be !== '0) begin
      miscompares++;
      $display("FAIL if_read_drive: if_gnt=%b ls_gnt=%b en=%b addr=%0d we=%b be=%b expected 1/0/1/5/0/0",
               if_gnt, ls_gnt, mem_en, mem_addr, mem_we, mem_be);
    end
    push_exp(1'b1, 32'hDEADBEEF);
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_ls_write_read();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = AW'(3);
    ls_be    = 4'b0011;
    ls_wdata = 32'h12345678;
    #1;
    vectors++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
        mem_addr !== AW'(3) || mem_wdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ls_write_drive: ls_gnt=%b we=%b be=%b addr=%0d wdata=%h expected 1/1/0011/3/12345678",
               ls_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    end
    ref_mem[3][15:0] = 16'h5678;
    tick();
    ls_we    = 1'b0;
    ls_be    = 4'b1111;
    ls_wdata = 32'hFFFFFFFF;
    #1;
    vectors++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b0 || mem_be !== '0 || mem_wdata !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL ls_read_drive: ls_gnt=%b we=%b be=%b wdata=%h expected 1/0/0000/ffffffff",
               ls_gnt, mem_we, mem_be, mem_wdata);
    end
    push_exp(1'b0, 32'h00005678);
    tick();
    set_idle();
    tick();
  endtask

  // Both requests held: LS wins MAXW cycles, then IF gets one.
  task automatic test_starvation();
    bit exp_if;
    preload(AW'(20), 32'hA5A5_0020);
    preload(AW'(21), 32'h5A5A_0021);
    if_req  = 1'b1;
    if_addr = AW'(20);
    ls_req  = 1'b1;
    ls_addr = AW'(21);
    for (int k = 1; k <= 10; k++) begin
      exp_if = (k % (MAXW + 1) == 0);
      #1;
      vectors++;
      if (if_gnt !== exp_if || ls_gnt !== !exp_if || mem_en !== 1'b1 ||
          mem_addr !== (exp_if ? AW'(20) : AW'(21))) begin
        miscompares++;
        $display("FAIL starve_c%0d: if_gnt=%b ls_gnt=%b en=%b addr=%0d expected if_gnt=%b",
                 k, if_gnt, ls_gnt, mem_en, mem_addr, exp_if);
      end
      push_exp(exp_if, exp_if ? ref_mem[20] : ref_mem[21]);
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    preload(AW'(10), 32'hCAFE_0010);
    preload(AW'(11), 32'hBEEF_0011);
    if_req  = 1'b1;
    if_addr = AW'(10);
    #1;
    vectors++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_if: if_gnt=%b ls_gnt=%b expected 1/0", if_gnt, ls_gnt);
    end
    push_exp(1'b1, 32'hCAFE_0010);
    tick();
    if_req  = 1'b0;
    ls_req  = 1'b1;
    ls_addr = AW'(11);
    #1;
    vectors++;
    if (if_gnt !== 1'b0 || ls_gnt !== 1'b1 || mem_addr !== AW'(11)) begin
      miscompares++;
      $display("FAIL b2b_ls: if_gnt=%b ls_gnt=%b addr=%0d expected 0/1/11",
               if_gnt, ls_gnt, mem_addr);
    end
    push_exp(1'b0, 32'hBEEF_0011);
    tick();
    // LS write contends with IF read: LS wins and produces no rvalid.
    if_req   = 1'b1;
    ls_we    = 1'b1;
    ls_be    = 4'b1111;
    ls_addr  = AW'(12);
    ls_wdata = 32'h0BAD_F00D;
    #1;
    vectors++;
    if (if_gnt !== 1'b0 || ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111) begin
      miscompares++;
      $display("FAIL b2b_wr_vs_if: if_gnt=%b ls_gnt=%b we=%b be=%b expected 0/1/1/1111",
               if_gnt, ls_gnt, mem_we, mem_be);
    end
    ref_mem[12] = 32'h0BAD_F00D;
    tick();
    ls_req = 1'b0;
    ls_we  = 1'b0;
    #1;
    vectors++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_if_after_wr: if_gnt=%b ls_gnt=%b expected 1/0", if_gnt, ls_gnt);
    end
    push_exp(1'b1, ref_mem[10]);
    tick();
    if_req = 1'b0;
    ls_req = 1'b1;
    #1;
    vectors++;
    if (ls_gnt !== 1'b1 || mem_addr !== AW'(12)) begin
      miscompares++;
      $display("FAIL b2b_ls_readback: ls_gnt=%b addr=%0d expected 1/12", ls_gnt, mem_addr);
    end
    push_exp(1'b0, 32'h0BAD_F00D);
    tick();
    set_idle();
    tick();
  endtask

  // Contention runs interrupted by reset; the 4:1 pattern must restart.
  task automatic test_reset_mid_op();
    int lost;
    bit exp_if;
    int seg_len [3] = '{MAXW + 1, 2, MAXW};
    preload(AW'(30), 32'h3030_3030);
    preload(AW'(31), 32'h3131_3131);
    for (int seg = 0; seg < 4; seg++) begin
      lost    = 0;
      if_req  = 1'b1;
      if_addr = AW'(30);
      ls_req  = 1'b1;
      ls_addr = AW'(31);
      for (int k = 0; k < ((seg < 3) ? seg_len[seg] : MAXW + 1); k++) begin
        exp_if = (lost == int'(MAXW));
        #1;
        vectors++;
        if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin
          miscompares++;
          $display("FAIL rst_mid_s%0d_c%0d: if_gnt=%b ls_gnt=%b expected if_gnt=%b",
                   seg, k, if_gnt, ls_gnt, exp_if);
        end
        push_exp(exp_if, exp_if ? ref_mem[30] : ref_mem[31]);
        lost = exp_if ? 0 : lost + 1;
        tick();
      end
      if (seg < 3) begin
        rst = 1'b1;
        #1;
        vectors++;
        if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_en !== 1'b0) begin
          miscompares++;
          $display("FAIL rst_mid_s%0d_gnt: if_gnt=%b ls_gnt=%b en=%b expected 0/0/0",
                   seg, if_gnt, ls_gnt, mem_en);
        end
        tick();
        rst = 1'b0;
      end
    end
    set_idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst     = 1'b1;
    pl_en   = 1'b0;
    pl_clr  = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_if_read();
    test_ls_write_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid_op();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
